// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the comparator arbiter: FSM encoding,
// requester count, ID width and the round-robin pick helper.
package cmp_arb_pkg;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMP  = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef logic [ID_W-1:0] id_t;

    // First set bit of req at or above ptr, wrapping; descending scan so the
    // nearest index is the last assignment. 2-bit add wraps mod NREQ.
    function automatic id_t rr_pick(input logic [NREQ-1:0] req, input id_t ptr);
        id_t idx;
        rr_pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + id_t'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/cmp_arb_if.sv
// Request/response bundle between the requesters/consumer and cmp_arb.
interface cmp_arb_if #(parameter int bits = 4);
    import cmp_arb_pkg::*;

    logic [NREQ-1:0]      req;
    logic [NREQ*bits-1:0] a_in;
    logic [NREQ*bits-1:0] b_in;
    logic [NREQ-1:0]      gnt;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_lt;
    logic                 rsp_gt;
    logic                 rsp_et;

    modport master (
        output req, a_in, b_in, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_lt, rsp_gt, rsp_et
    );

    modport slave (
        input  req, a_in, b_in, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_lt, rsp_gt, rsp_et
    );

endinterface

// File: rtl/comp.sv
// Unsigned magnitude comparator shared by all requesters of cmp_arb.
module comp #(
    parameter int bits = 4
) (
    input  logic [bits-1:0] in1,
    input  logic [bits-1:0] in2,
    output logic            Lt,
    output logic            Gt,
    output logic            Et
);

    assign Lt = (in1 <  in2);
    assign Gt = (in1 >  in2);
    assign Et = (in1 == in2);

endmodule

// File: rtl/cmp_arb.sv
// Round-robin arbiter sharing one comparator among NREQ requesters:
// grant, compare, then hold the response until the consumer takes it.
module cmp_arb
    import cmp_arb_pkg::*;
#(
    parameter int bits = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    cmp_arb_if.slave   bus
);

    state_t          state, state_nx;
    id_t             ptr, win, pick;
    logic [bits-1:0] op_a, op_b, sel_a, sel_b;
    logic            lt, gt, et;
    logic            grant_en, rsp_en, done;

    always_comb begin
        pick  = rr_pick(bus.req, ptr);
        sel_a = bus.a_in[int'(pick)*bits +: bits];
        sel_b = bus.b_in[int'(pick)*bits +: bits];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        rsp_en   = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: if (|bus.req) begin
                grant_en = 1'b1;
                state_nx = CMP;
            end
            CMP: begin
                rsp_en   = 1'b1;
                state_nx = RESP;
            end
            RESP: if (bus.rsp_ready) begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // gnt defaults low every edge, so it lives exactly for the CMP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            win           <= '0;
            op_a          <= '0;
            op_b          <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_lt    <= 1'b0;
            bus.rsp_gt    <= 1'b0;
            bus.rsp_et    <= 1'b0;
        end else begin
            bus.gnt <= '0;
            if (grant_en) begin
                win          <= pick;
                op_a         <= sel_a;
                op_b         <= sel_b;
                bus.gnt[pick] <= 1'b1;
            end
            if (rsp_en) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_id    <= win;
                bus.rsp_lt    <= lt;
                bus.rsp_gt    <= gt;
                bus.rsp_et    <= et;
            end
            if (done) begin
                bus.rsp_valid <= 1'b0;
                ptr           <= win + id_t'(1);
            end
        end
    end

    comp #(.bits(bits)) u_comp (
        .in1 (op_a),
        .in2 (op_b),
        .Lt  (lt),
        .Gt  (gt),
        .Et  (et)
    );

endmodule

// File: tb/tb_cmp_arb.sv
// Self-checking bench for cmp_arb: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_cmp_arb;

    localparam int BITS = 4;
    localparam int N    = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    cmp_arb_if #(.bits(BITS)) bus ();

    cmp_arb #(.bits(BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: 0 free, 1 granted, 2 response outstanding
    int             m_phase;
    int             m_ptr;
    int             m_id;
    int             m_a, m_b;
    logic [N-1:0]   m_gnt;
    logic           m_vld, m_lt, m_gt, m_et;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int p);
        int w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && r[(p + k) % N]) w = (p + k) % N;
        return w;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_id = 0; m_a = 0; m_b = 0;
        m_gnt = '0; m_vld = 1'b0; m_lt = 1'b0; m_gt = 1'b0; m_et = 1'b0;
    endtask

    // Applied at each rising edge using the inputs that were stable before it.
    task automatic model_edge();
        int w;
        case (m_phase)
            0: begin
                m_gnt = '0;
                if (bus.req != '0) begin
                    w = rr(bus.req, m_ptr);
                    m_id = w;
                    m_a = int'(bus.a_in[w*BITS +: BITS]);
                    m_b = int'(bus.b_in[w*BITS +: BITS]);
                    m_gnt[w] = 1'b1;
                    m_phase = 1;
                end
            end
            1: begin
                m_gnt = '0;
                m_vld = 1'b1;
                m_lt = (m_a < m_b);
                m_gt = (m_a > m_b);
                m_et = (m_a == m_b);
                m_phase = 2;
            end
            default: if (bus.rsp_ready) begin
                m_vld = 1'b0;
                m_ptr = (m_id + 1) % N;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic check_out();
        chk("gnt", 32'(bus.gnt), 32'(m_gnt));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_vld));
        if (m_vld) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
            chk("rsp_lt", 32'(bus.rsp_lt), 32'(m_lt));
            chk("rsp_gt", 32'(bus.rsp_gt), 32'(m_gt));
            chk("rsp_et", 32'(bus.rsp_et), 32'(m_et));
            chk("onehot", 32'(bus.rsp_lt) + 32'(bus.rsp_gt) + 32'(bus.rsp_et), 32'd1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_out();
    endtask

    // Called at a falling edge; reset is released well before the next rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int gnt_idx(input logic [N-1:0] g);
        int w = -1;
        for (int k = 0; k < N; k++) if (g[k]) w = k;
        return w;
    endfunction

    task automatic set_ops(input int idx, input int a, input int b);
        bus.a_in[idx*BITS +: BITS] = BITS'(a);
        bus.b_in[idx*BITS +: BITS] = BITS'(b);
    endtask

    initial begin
        int gq[$];
        int tq[$];
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.rsp_ready = 1'b0;
        model_reset();

        // Asynchronous reset before any clock edge
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("r_gnt", 32'(bus.gnt), 32'd0);
        chk("r_valid", 32'(bus.rsp_valid), 32'd0);
        chk("r_id", 32'(bus.rsp_id), 32'd0);
        chk("r_lt", 32'(bus.rsp_lt), 32'd0);
        chk("r_gt", 32'(bus.rsp_gt), 32'd0);
        chk("r_et", 32'(bus.rsp_et), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request 3 vs 7
        bus.req = 4'b0001; set_ops(0, 3, 7); bus.rsp_ready = 1'b1;
        step();
        chk("t1_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        step();
        chk("t1_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_id", 32'(bus.rsp_id), 32'd0);
        chk("t1_lt", {bus.rsp_lt, bus.rsp_gt, bus.rsp_et}, 32'b100);
        step();

        // All requesting, equal operands: strict rotation every 3 cycles
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) set_ops(i, 7, 7);
        for (int c = 0; c < 13; c++) begin
            step();
            if (bus.gnt != '0) begin gq.push_back(gnt_idx(bus.gnt)); tq.push_back(c); end
        end
        chk("rot_count", 32'(gq.size()), 32'd5);
        for (int i = 0; i < 5 && i < gq.size(); i++) begin
            chk("rot_order", 32'(gq[i]), 32'(exp_order[i]));
            if (i > 0) chk("rot_space", 32'(tq[i] - tq[i-1]), 32'd3);
        end
        bus.req = '0;
        step(); step(); step();

        // Backpressure with operand change after grant
        do_reset();
        bus.req = 4'b0100; set_ops(2, 15, 14); bus.rsp_ready = 1'b0;
        step();
        bus.req = '0; bus.a_in = '0;
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold", {bus.rsp_valid, 2'(bus.rsp_id), bus.rsp_gt}, 32'b1101);
        end
        bus.rsp_ready = 1'b1;
        step();

        // Pointer at 2 with requesters 1 and 3 pending
        do_reset();
        bus.req = 4'b0010;
        step(); bus.req = '0; step(); step();
        bus.req = 4'b1010;
        gq.delete();
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.gnt != '0) gq.push_back(gnt_idx(bus.gnt));
            if (gq.size() == 2) bus.req = '0;
        end
        chk("rr_count", 32'(gq.size()), 32'd2);
        if (gq.size() == 2) begin
            chk("rr_first", 32'(gq[0]), 32'd3);
            chk("rr_second", 32'(gq[1]), 32'd1);
        end
        bus.req = 4'b1111;
        step();
        chk("rr_ptr2", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        step(); step();

        // Reset while a response is outstanding
        bus.req = 4'b1000; bus.rsp_ready = 1'b0;
        step(); bus.req = '0; step();
        chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        do_reset();
        bus.req = 4'b1111; bus.rsp_ready = 1'b1;
        step();
        chk("post_rst_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        step(); step();

        // Long idle, then a 0/0 compare on requester 1
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_gnt", 32'(bus.gnt), 32'd0);
        end
        bus.req = 4'b0010; set_ops(1, 0, 0);
        step(); bus.req = '0; step();
        chk("zero_et", {bus.rsp_lt, bus.rsp_gt, bus.rsp_et}, 32'b001);
        step();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(3) != 0) bus.req = N'($urandom);
            if ($urandom_range(1) != 0) begin
                bus.a_in = (N*BITS)'($urandom);
                bus.b_in = (N*BITS)'($urandom);
            end
            bus.rsp_ready = ($urandom_range(2) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
